uart_cmd_parser: RTL and testbench

Byte-stream command parser that sits directly downstream of `uart_rx` and upstream of the transmit path (TX FIFO / `uart_tx`). It assembles ASCII hex command frames from received bytes and executes them as single-cycle register-bus reads or writes. It then emits an ASCII response byte stream on a valid/ready interface. This turns the UART loopback into a host-accessible register port.

---
 rtl/uart_cmd_parser.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: ASCII hex frames (W/R) to register bus, ASCII replies.
// Define UART_CMD_PARSER_ECHO_EN to echo accepted bytes before processing.
module uart_cmd_parser #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              cmd_err
);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA_HI, S_DATA_LO,
    S_WAIT_CR, S_DRAIN, S_EXEC, S_RD_WAIT, S_RESP
  } state_t;

  state_t            state_q;
  logic              op_wr_q;
  logic [7:0]        addr_tmp_q;
  logic [7:0]        data_tmp_q;
  logic [CW-1:0]     cnt_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic [7:0]        b1_q;
  logic [7:0]        b2_q;
  logic [1:0]        rem_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [DATA_W-1:0] reg_wdata_q;
  logic              wr_q;
  logic              rd_q;
  logic              err_q;

  logic       rcv;
  logic       acc;
  logic       ign;
  logic       evt;
  logic       echo_pend;
  logic [7:0] evt_byte;
  logic [7:0] rd8;

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) ||
           (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] b);
    if (b <= 8'h39) return b[3:0];
    return b[3:0] + 4'd9;
  endfunction

  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic is_w(input logic [7:0] b);
    return b == 8'h57 || b == 8'h77;
  endfunction

  function automatic logic is_r(input logic [7:0] b);
    return b == 8'h52 || b == 8'h72;
  endfunction

  // Receive-state decode, acceptance and which byte drives the FSM.
  always_comb begin
    rcv = state_q inside {S_IDLE, S_ADDR_HI, S_ADDR_LO,
                          S_DATA_HI, S_DATA_LO, S_WAIT_CR, S_DRAIN};
    rx_ready = rcv && !echo_pend;
    acc = rx_valid && rx_ready;
    ign = (rx_data == CH_LF) ||
          (state_q == S_IDLE &&
           (rx_data == CH_CR || rx_data == CH_SP));
`ifdef UART_CMD_PARSER_ECHO_EN
    evt = echo_pend && tx_ready;
    evt_byte = tx_data_q;
`else
    evt = acc && !ign;
    evt_byte = rx_data;
`endif
    rd8 = '0;
    rd8[DATA_W-1:0] = reg_rdata;
  end

`ifdef UART_CMD_PARSER_ECHO_EN
  logic echo_q;
  assign echo_pend = echo_q;

  // Echo holds the byte on tx; FSM consumes it on the echo handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) echo_q <= 1'b0;
    else if (acc && !ign) echo_q <= 1'b1;
    else if (echo_q && tx_ready) echo_q <= 1'b0;
  end
`else
  assign echo_pend = 1'b0;
`endif

  // Main FSM: frame assembly, bus strobes, timeout and response queue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      op_wr_q     <= 1'b0;
      addr_tmp_q  <= '0;
      data_tmp_q  <= '0;
      cnt_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      b1_q        <= '0;
      b2_q        <= '0;
      rem_q       <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      err_q <= 1'b0;
`ifdef UART_CMD_PARSER_ECHO_EN
      if (echo_pend && tx_ready) tx_valid_q <= 1'b0;
      if (acc && !ign) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= rx_data;
      end
`endif
      if (acc) begin
        cnt_q <= '0;
      end else if (rcv && state_q != S_IDLE && !echo_pend) begin
        if (cnt_q == TO_LAST) begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      unique case (state_q)
        S_IDLE: if (evt) begin
          if (is_w(evt_byte) || is_r(evt_byte)) begin
            op_wr_q <= is_w(evt_byte);
            state_q <= S_ADDR_HI;
          end else begin
            state_q <= S_DRAIN;
          end
        end
        S_ADDR_HI: if (evt) begin
          if (is_hex(evt_byte)) begin
            addr_tmp_q[7:4] <= hex_val(evt_byte);
            state_q <= S_ADDR_LO;
          end else state_q <= S_DRAIN;
        end
        S_ADDR_LO: if (evt) begin
          if (is_hex(evt_byte)) begin
            addr_tmp_q[3:0] <= hex_val(evt_byte);
            state_q <= op_wr_q ? S_DATA_HI : S_WAIT_CR;
          end else state_q <= S_DRAIN;
        end
        S_DATA_HI: if (evt) begin
          if (is_hex(evt_byte)) begin
            data_tmp_q[7:4] <= hex_val(evt_byte);
            state_q <= S_DATA_LO;
          end else state_q <= S_DRAIN;
        end
        S_DATA_LO: if (evt) begin
          if (is_hex(evt_byte)) begin
            data_tmp_q[3:0] <= hex_val(evt_byte);
            state_q <= S_WAIT_CR;
          end else state_q <= S_DRAIN;
        end
        S_WAIT_CR: if (evt) begin
          if (evt_byte == CH_CR) begin
            reg_addr_q <= addr_tmp_q[ADDR_W-1:0];
            if (op_wr_q) begin
              reg_wdata_q <= data_tmp_q[DATA_W-1:0];
              wr_q <= 1'b1;
            end else begin
              rd_q <= 1'b1;
            end
            state_q <= S_EXEC;
          end else state_q <= S_DRAIN;
        end
        S_DRAIN: if (evt && evt_byte == CH_CR) begin
          err_q      <= 1'b1;
          tx_valid_q <= 1'b1;
          tx_data_q  <= 8'h45;
          b1_q       <= CH_CR;
          rem_q      <= 2'd1;
          state_q    <= S_RESP;
        end
        S_EXEC: begin
          if (op_wr_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= 8'h4B;
            b1_q       <= CH_CR;
            rem_q      <= 2'd1;
            state_q    <= S_RESP;
          end else begin
            state_q <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          tx_valid_q <= 1'b1;
          tx_data_q  <= hex_chr(rd8[7:4]);
          b1_q       <= hex_chr(rd8[3:0]);
          b2_q       <= CH_CR;
          rem_q      <= 2'd2;
          state_q    <= S_RESP;
        end
        S_RESP: if (tx_ready) begin
          if (rem_q == 2'd0) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            tx_data_q <= b1_q;
            b1_q      <= b2_q;
            rem_q     <= rem_q - 2'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr_en = wr_q;
  assign reg_rd_en = rd_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser (default build, no echo).
// Expected values are hand-computed ASCII/bus results.
module tb_uart_cmd_parser;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata = 8'h00;
  logic       cmd_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] txq[$];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int err_cnt = 0;
  logic [7:0] last_wa = 8'h00;
  logic [7:0] last_wd = 8'h00;
  logic [7:0] last_ra = 8'h00;

  uart_cmd_parser #(
    .ADDR_W(8),
    .DATA_W(8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en),
    .reg_rdata(reg_rdata),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Record tx handshakes and bus strobes mid-cycle.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (reg_wr_en) begin
      wr_cnt++;
      last_wa = reg_addr;
      last_wd = reg_wdata;
    end
    if (reg_rd_en) begin
      rd_cnt++;
      last_ra = reg_addr;
    end
    if (cmd_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] qget(input int i);
    if (i >= txq.size()) return 8'hFF;
    return txq[i];
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    while (rx_ready !== 1'b1 && n < 100) begin
      cyc(1);
      n++;
    end
    if (n >= 100) chk("rx_ready_wait", {31'd0, rx_ready}, 1);
    rx_data = b;
    rx_valid = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  initial begin
    cyc(2);
    chk("rst_rx_ready", {31'd0, rx_ready}, 1);
    chk("rst_tx_valid", {31'd0, tx_valid}, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 0);
    chk("rst_wr_en", {31'd0, reg_wr_en}, 0);
    chk("rst_rd_en", {31'd0, reg_rd_en}, 0);
    chk("rst_cmd_err", {31'd0, cmd_err}, 0);
    chk("rst_addr", {24'd0, reg_addr}, 0);
    chk("rst_wdata", {24'd0, reg_wdata}, 0);
    resetn = 1'b1;
    cyc(2);

    // Write 0x5C to 0x3A.
    txq.delete();
    send_str("W3A5C");
    send(8'h0D);
    chk("w_wr_en_n1", {31'd0, reg_wr_en}, 1);
    chk("w_rx_ready_n1", {31'd0, rx_ready}, 0);
    chk("w_tx_valid_n1", {31'd0, tx_valid}, 0);
    cyc(1);
    chk("w_wr_en_n2", {31'd0, reg_wr_en}, 0);
    chk("w_tx_valid_n2", {31'd0, tx_valid}, 1);
    chk("w_tx_data_n2", {24'd0, tx_data}, 32'h4B);
    cyc(6);
    chk("w_cnt", wr_cnt, 1);
    chk("w_addr", {24'd0, last_wa}, 32'h3A);
    chk("w_data", {24'd0, last_wd}, 32'h5C);
    chk("w_nbytes", txq.size(), 2);
    chk("w_b0", {24'd0, qget(0)}, 32'h4B);
    chk("w_b1", {24'd0, qget(1)}, 32'h0D);
    chk("w_rx_ready_end", {31'd0, rx_ready}, 1);

    // Lowercase read of 0x3A, data 0xF0.
    txq.delete();
    reg_rdata = 8'hF0;
    send_str("r3a");
    send(8'h0D);
    chk("r_rd_en_n1", {31'd0, reg_rd_en}, 1);
    chk("r_addr_n1", {24'd0, reg_addr}, 32'h3A);
    cyc(1);
    chk("r_tx_valid_n2", {31'd0, tx_valid}, 0);
    cyc(1);
    chk("r_tx_valid_n3", {31'd0, tx_valid}, 1);
    chk("r_tx_data_n3", {24'd0, tx_data}, 32'h46);
    cyc(6);
    chk("r_cnt", rd_cnt, 1);
    chk("r_nbytes", txq.size(), 3);
    chk("r_b0", {24'd0, qget(0)}, 32'h46);
    chk("r_b1", {24'd0, qget(1)}, 32'h30);
    chk("r_b2", {24'd0, qget(2)}, 32'h0D);

    // Bad hex digit -> error response, then a clean read.
    txq.delete();
    send_str("WZ1");
    send(8'h0D);
    chk("e_cmd_err_n1", {31'd0, cmd_err}, 1);
    chk("e_tx_valid_n1", {31'd0, tx_valid}, 1);
    chk("e_tx_data_n1", {24'd0, tx_data}, 32'h45);
    cyc(1);
    chk("e_cmd_err_n2", {31'd0, cmd_err}, 0);
    cyc(5);
    chk("e_err_cnt", err_cnt, 1);
    chk("e_wr_cnt", wr_cnt, 1);
    chk("e_nbytes", txq.size(), 2);
    chk("e_b0", {24'd0, qget(0)}, 32'h45);
    chk("e_b1", {24'd0, qget(1)}, 32'h0D);
    txq.delete();
    reg_rdata = 8'h7B;
    send(8'h0D);
    send(8'h20);
    send_str("R0");
    send(8'h0A);
    send_str("0");
    send(8'h0D);
    cyc(8);
    chk("e2_rd_cnt", rd_cnt, 2);
    chk("e2_addr", {24'd0, last_ra}, 32'h00);
    chk("e2_nbytes", txq.size(), 3);
    chk("e2_b0", {24'd0, qget(0)}, 32'h37);
    chk("e2_b1", {24'd0, qget(1)}, 32'h42);
    chk("e2_err_cnt", err_cnt, 1);

    // Partial frame times out silently.
    txq.delete();
    send_str("W12");
    cyc(TO + 2);
    chk("to_nbytes_idle", txq.size(), 0);
    reg_rdata = 8'hA5;
    send_str("R12");
    send(8'h0D);
    cyc(8);
    chk("to_rd_cnt", rd_cnt, 3);
    chk("to_addr", {24'd0, last_ra}, 32'h12);
    chk("to_err_cnt", err_cnt, 1);
    chk("to_wr_cnt", wr_cnt, 1);
    chk("to_nbytes", txq.size(), 3);
    chk("to_b0", {24'd0, qget(0)}, 32'h41);
    chk("to_b1", {24'd0, qget(1)}, 32'h35);

    // Backpressure: tx held, rx byte during response dropped.
    txq.delete();
    tx_ready = 1'b0;
    reg_rdata = 8'h3C;
    send_str("R05");
    send(8'h0D);
    cyc(2);
    for (int i = 0; i < 10; i++) begin
      chk("bp_tx_valid", {31'd0, tx_valid}, 1);
      chk("bp_tx_data", {24'd0, tx_data}, 32'h33);
      chk("bp_rx_ready", {31'd0, rx_ready}, 0);
      rx_data = 8'h57;
      rx_valid = (i == 4);
      cyc(1);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    cyc(6);
    chk("bp_nbytes", txq.size(), 3);
    chk("bp_b0", {24'd0, qget(0)}, 32'h33);
    chk("bp_b1", {24'd0, qget(1)}, 32'h43);
    chk("bp_b2", {24'd0, qget(2)}, 32'h0D);
    chk("bp_rx_ready_end", {31'd0, rx_ready}, 1);
    chk("bp_err_cnt", err_cnt, 1);

    // Reset mid-response, then a normal write.
    txq.delete();
    reg_rdata = 8'h99;
    send_str("R01");
    send(8'h0D);
    cyc(3);
    chk("rr_tx_valid_pre", {31'd0, tx_valid}, 1);
    resetn = 1'b0;
    #1;
    chk("rr_rx_ready", {31'd0, rx_ready}, 1);
    chk("rr_tx_valid", {31'd0, tx_valid}, 0);
    chk("rr_tx_data", {24'd0, tx_data}, 0);
    chk("rr_addr", {24'd0, reg_addr}, 0);
    chk("rr_wdata", {24'd0, reg_wdata}, 0);
    chk("rr_strobes", {29'd0, reg_wr_en, reg_rd_en, cmd_err}, 0);
    #2;
    resetn = 1'b1;
    cyc(2);
    txq.delete();
    send_str("W0001");
    send(8'h0D);
    cyc(6);
    chk("rr_wr_cnt", wr_cnt, 2);
    chk("rr_w_addr", {24'd0, last_wa}, 32'h00);
    chk("rr_w_data", {24'd0, last_wd}, 32'h01);
    chk("rr_nbytes", txq.size(), 2);
    chk("rr_b0", {24'd0, qget(0)}, 32'h4B);
    chk("rr_b1", {24'd0, qget(1)}, 32'h0D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
